// File: rtl/cpu_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, IR field
// positions, sequencer states and the opcode-class helper.
package cpu_pkg;

   localparam int unsigned NUM_REGS  = 16;
   localparam int unsigned OP_W      = 5;
   localparam int unsigned REG_IDX_W = 4;
   localparam int unsigned IR_W      = 32;

   // IR field bit positions
   localparam int unsigned OP_MSB = 31;
   localparam int unsigned OP_LSB = 27;
   localparam int unsigned RA_MSB = 26;
   localparam int unsigned RA_LSB = 23;
   localparam int unsigned RB_MSB = 22;
   localparam int unsigned RB_LSB = 19;
   localparam int unsigned RC_MSB = 18;
   localparam int unsigned RC_LSB = 15;

   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
   localparam logic [OP_W-1:0] OP_ROR  = 5'b01001;
   localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11011;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11100;

   typedef enum logic [3:0] {
      ST_RESET  = 4'd0,
      ST_T0     = 4'd1,
      ST_T1     = 4'd2,
      ST_T2     = 4'd3,
      ST_T3     = 4'd4,
      ST_T4     = 4'd5,
      ST_T5     = 4'd6,
      ST_T6     = 4'd7,
      ST_HALTED = 4'd8
   } state_e;

   typedef enum logic [2:0] {
      CLS_NOP    = 3'd0,
      CLS_BIN    = 3'd1,
      CLS_ADDI   = 3'd2,
      CLS_MULDIV = 3'd3,
      CLS_UNARY  = 3'd4,
      CLS_HALT   = 3'd5
   } op_class_e;

   // Map an opcode to its execute-sequence class; unknown opcodes run as nop.
   function automatic op_class_e classify(input logic [OP_W-1:0] op);
      op_class_e cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_BIN;
         OP_ADDI:                        cls = CLS_ADDI;
         OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
         OP_NEG, OP_NOT:                 cls = CLS_UNARY;
         OP_HALT:                        cls = CLS_HALT;
         default:                        cls = CLS_NOP;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface control_sequencer_if;
   import cpu_pkg::*;

   logic [IR_W-1:0]     IR;
   logic                Stop;
   logic [OP_W-1:0]     opcode;
   logic [NUM_REGS-1:0] Rin;
   logic [NUM_REGS-1:0] Rout;
   logic                PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
   logic                PCout, MDRout, Zhighout, Zlowout, Cout;
   logic                Read, IncPC, Run;

   modport master (
      input  IR, Stop,
      output opcode, Rin, Rout,
      output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
      output PCout, MDRout, Zhighout, Zlowout, Cout,
      output Read, IncPC, Run
   );

   modport slave (
      output IR, Stop,
      input  opcode, Rin, Rout,
      input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
      input  PCout, MDRout, Zhighout, Zlowout, Cout,
      input  Read, IncPC, Run
   );
endinterface

// File: rtl/reg_select_decoder.sv
// 4-bit register index plus enable to a one-hot register select.
module reg_select_decoder
   import cpu_pkg::*;
(
   input  logic [REG_IDX_W-1:0] idx_i,
   input  logic                 en_i,
   output logic [NUM_REGS-1:0]  sel_o
);

   // One-hot decode, all zeros when disabled
   always_comb begin
      sel_o = '0;
      if (en_i) sel_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, opcode-dependent execute T3-T6.
// Outputs are a Moore decode of the state register and the datapath's
// latched IR; the IR is only loaded on the T2 edge, so T3 strobes cannot be
// pre-registered and are decoded directly.
module control_sequencer
   import cpu_pkg::*;
(
   input  logic                Clock,
   input  logic                clear,
   control_sequencer_if.master bus
);

   state_e              state_q, state_d;
   logic [OP_W-1:0]     op;
   logic [REG_IDX_W-1:0] ra, rb, rc;
   op_class_e           cls;
   state_e              boundary_next;
   logic [REG_IDX_W-1:0] rin_idx, rout_idx;
   logic                rin_en, rout_en;
   logic [NUM_REGS-1:0] rin_sel, rout_sel;
   logic [RC_LSB-1:0]   unused_ir;

   assign op        = bus.IR[OP_MSB:OP_LSB];
   assign ra        = bus.IR[RA_MSB:RA_LSB];
   assign rb        = bus.IR[RB_MSB:RB_LSB];
   assign rc        = bus.IR[RC_MSB:RC_LSB];
   assign unused_ir = bus.IR[RC_LSB-1:0];
   assign cls       = classify(op);

   // Where the last execute state of an instruction goes
   assign boundary_next = bus.Stop ? ST_HALTED : ST_T0;

   // State register, async clear to RESET
   always_ff @(posedge Clock or posedge clear) begin
      if (clear) state_q <= ST_RESET;
      else       state_q <= state_d;
   end

   // Next-state and control-strobe decode
   always_comb begin
      state_d      = state_q;
      bus.opcode   = '0;
      bus.PCin     = 1'b0;
      bus.IRin     = 1'b0;
      bus.MARin    = 1'b0;
      bus.MDRin    = 1'b0;
      bus.Yin      = 1'b0;
      bus.Zin      = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.PCout    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.Zhighout = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Cout     = 1'b0;
      bus.Read     = 1'b0;
      bus.IncPC    = 1'b0;
      bus.Run      = 1'b0;
      rin_idx      = ra;
      rin_en       = 1'b0;
      rout_idx     = rb;
      rout_en      = 1'b0;

      case (state_q)
         ST_RESET: begin
            state_d = ST_T0;
         end
         ST_T0: begin
            state_d   = ST_T1;
            bus.Run   = 1'b1;
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.Zin   = 1'b1;
         end
         ST_T1: begin
            state_d     = ST_T2;
            bus.Run     = 1'b1;
            bus.Zlowout = 1'b1;
            bus.PCin    = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
         end
         ST_T2: begin
            state_d    = ST_T3;
            bus.Run    = 1'b1;
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         ST_T3: begin
            bus.Run = 1'b1;
            case (cls)
               CLS_HALT: state_d = ST_HALTED;
               CLS_NOP:  state_d = boundary_next;
               default:  state_d = ST_T4;
            endcase
            case (cls)
               CLS_BIN, CLS_ADDI: begin
                  rout_idx = rb;
                  rout_en  = 1'b1;
                  bus.Yin  = 1'b1;
               end
               CLS_MULDIV: begin
                  rout_idx = ra;
                  rout_en  = 1'b1;
                  bus.Yin  = 1'b1;
               end
               CLS_UNARY: begin
                  rout_idx   = rb;
                  rout_en    = 1'b1;
                  bus.opcode = op;
                  bus.Zin    = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            bus.Run = 1'b1;
            state_d = (cls == CLS_UNARY) ? boundary_next : ST_T5;
            case (cls)
               CLS_BIN: begin
                  rout_idx   = rc;
                  rout_en    = 1'b1;
                  bus.opcode = op;
                  bus.Zin    = 1'b1;
               end
               CLS_ADDI: begin
                  bus.Cout   = 1'b1;
                  bus.opcode = OP_ADD;
                  bus.Zin    = 1'b1;
               end
               CLS_MULDIV: begin
                  rout_idx   = rb;
                  rout_en    = 1'b1;
                  bus.opcode = op;
                  bus.Zin    = 1'b1;
               end
               CLS_UNARY: begin
                  rin_idx     = ra;
                  rin_en      = 1'b1;
                  bus.Zlowout = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            bus.Run     = 1'b1;
            state_d     = (cls == CLS_MULDIV) ? ST_T6 : boundary_next;
            bus.Zlowout = 1'b1;
            if (cls == CLS_MULDIV) begin
               bus.LOin = 1'b1;
            end else begin
               rin_idx = ra;
               rin_en  = 1'b1;
            end
         end
         ST_T6: begin
            state_d      = boundary_next;
            bus.Run      = 1'b1;
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   reg_select_decoder u_rin_dec (
      .idx_i (rin_idx),
      .en_i  (rin_en),
      .sel_o (rin_sel)
   );

   reg_select_decoder u_rout_dec (
      .idx_i (rout_idx),
      .en_i  (rout_en),
      .sel_o (rout_sel)
   );

   assign bus.Rin  = rin_sel;
   assign bus.Rout = rout_sel;

endmodule
